// File: rtl/tdm_demux4.sv
// tdm_demux4: receive end of the four-way select datapath. Splits a single
// WIDTH-bit TDM lane into NUM_CH parallel channels, aligned by a frame-sync
// strobe, and presents each completed frame with a one-cycle valid pulse.
//
// state  | meaning
// -------+---------------------------------------------------------------
// HUNT   | waiting for a sync beat; all non-sync beats are discarded
// LOCKED | aligned to the frame; slot tracks where the next beat belongs
module tdm_demux4 #(
  parameter int WIDTH  = 2,
  parameter int NUM_CH = 4
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_valid,
  input  logic                      in_sync,
  output logic [NUM_CH*WIDTH-1:0]   out_data,
  output logic                      out_valid,
  output logic [$clog2(NUM_CH)-1:0] slot,
  output logic                      locked,
  output logic                      sync_err
);

  localparam int SW = $clog2(NUM_CH);
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_CH - 1);

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shadow [NUM_CH-1];

  // locked is a pure decode of the registered state, so it is glitch-free
  assign locked = (state == LOCKED);

  // Frame alignment, slot capture and frame presentation
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= HUNT;
      slot      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
      for (int i = 0; i < NUM_CH - 1; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        case (state)
          HUNT: begin
            if (in_sync) begin
              shadow[0] <= in_data;
              slot      <= SW'(1);
              state     <= LOCKED;
            end
          end
          LOCKED: begin
            if (in_sync) begin
              // An early sync abandons the partial frame but stays aligned
              // to the new one, since the sync itself is trustworthy.
              if (slot != '0) begin
                sync_err <= 1'b1;
              end
              shadow[0] <= in_data;
              slot      <= SW'(1);
            end else if (slot == '0) begin
              // A frame start without sync means alignment is lost.
              sync_err <= 1'b1;
              state    <= HUNT;
            end else if (slot == LAST_SLOT) begin
              // The last slot goes straight to the output; it never needs
              // a shadow entry.
              for (int k = 0; k < NUM_CH - 1; k++) begin
                out_data[k*WIDTH +: WIDTH] <= shadow[k];
              end
              out_data[(NUM_CH-1)*WIDTH +: WIDTH] <= in_data;
              out_valid <= 1'b1;
              slot      <= '0;
            end else begin
              shadow[slot] <= in_data;
              slot         <= slot + SW'(1);
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Testbench for tdm_demux4 (WIDTH=2, NUM_CH=4): vector table for the slot /
// lock / error state, plus a scoreboard of expected frames with due cycles.
module tb_tdm_demux4;

  logic       CLOCK_50;
  logic       reset;
  logic [1:0] in_data;
  logic       in_valid;
  logic       in_sync;
  logic [7:0] out_data;
  logic       out_valid;
  logic [1:0] slot;
  logic       locked;
  logic       sync_err;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  typedef struct {
    logic       rst;
    logic       v;
    logic       s;
    logic [1:0] d;
    logic       push;
    logic [7:0] frame;
    logic [1:0] eslot;
    logic       elock;
    logic       eerr;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  tdm_demux4 #(.WIDTH(2), .NUM_CH(4)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_sync  (in_sync),
    .out_data (out_data),
    .out_valid(out_valid),
    .slot     (slot),
    .locked   (locked),
    .sync_err (sync_err)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cycle <= cycle + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic rst, input logic v, input logic s,
                              input logic [1:0] d, input logic push,
                              input logic [7:0] frame, input logic [1:0] eslot,
                              input logic elock, input logic eerr);
    vec_t t;
    t.rst = rst; t.v = v; t.s = s; t.d = d; t.push = push; t.frame = frame;
    t.eslot = eslot; t.elock = elock; t.eerr = eerr;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge, check registered state one cycle later
  task automatic apply(input vec_t t, input string tag);
    exp_t e;
    reset    = t.rst;
    in_valid = t.v;
    in_sync  = t.s;
    in_data  = t.d;
    if (t.push) begin
      e.data = t.frame;
      e.due  = cycle + 1;
      sb.push_back(e);
    end
    @(negedge CLOCK_50);
    chk({tag, "_slot"}, 32'(slot), 32'(t.eslot));
    chk({tag, "_locked"}, 32'(locked), 32'(t.elock));
    chk({tag, "_sync_err"}, 32'(sync_err), 32'(t.eerr));
  endtask

  // Output monitor: every pulse must match the oldest expected frame on time,
  // and no expected frame may go past its due cycle unseen.
  always @(negedge CLOCK_50) begin
    exp_t e;
    if (out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid: got out_data %0h at cycle %0d expected no pulse", out_data, cycle);
      end else begin
        e = sb.pop_front();
        if (out_data !== e.data || cycle != e.due) begin
          errors++;
          $display("FAIL frame: got %0h at cycle %0d expected %0h at cycle %0d", out_data, cycle, e.data, e.due);
        end
      end
    end else if (sb.size() != 0 && cycle > sb[0].due) begin
      checks++;
      errors++;
      e = sb.pop_front();
      $display("FAIL missing_out_valid: got no pulse by cycle %0d expected %0h at cycle %0d", cycle, e.data, e.due);
    end
  end

  initial begin
    logic [7:0] fr;
    logic [1:0] d;

    reset = 1'b1; in_valid = 1'b0; in_sync = 1'b0; in_data = '0;
    @(negedge CLOCK_50);

    // 1: basic frame
    vecs.push_back(mk(1, 0, 0, 2'b00, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 2'b00, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 2'b01, 0, 8'h00, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 2'b10, 0, 8'h00, 2, 1, 0));
    vecs.push_back(mk(0, 1, 0, 2'b11, 0, 8'h00, 3, 1, 0));
    vecs.push_back(mk(0, 1, 0, 2'b00, 1, 8'h39, 0, 1, 0));
    // 2: gapped beats
    vecs.push_back(mk(0, 1, 1, 2'b01, 0, 8'h00, 1, 1, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 1, 2'b11, 0, 8'h00, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 2'b10, 0, 8'h00, 2, 1, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 2'b01, 0, 8'h00, 2, 1, 0));
    vecs.push_back(mk(0, 1, 0, 2'b11, 0, 8'h00, 3, 1, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 1, 2'b00, 0, 8'h00, 3, 1, 0));
    vecs.push_back(mk(0, 1, 0, 2'b00, 1, 8'h39, 0, 1, 0));
    // 3: hunt discard (second reset row carries a sync beat that reset must override)
    vecs.push_back(mk(1, 0, 0, 2'b00, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 2'b01, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 2'b11, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 2'b11, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 2'b01, 0, 8'h00, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 2'b10, 0, 8'h00, 2, 1, 0));
    vecs.push_back(mk(0, 1, 0, 2'b11, 0, 8'h00, 3, 1, 0));
    vecs.push_back(mk(0, 1, 0, 2'b00, 1, 8'h39, 0, 1, 0));
    // 4: early sync
    vecs.push_back(mk(0, 1, 1, 2'b01, 0, 8'h00, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 2'b10, 0, 8'h00, 2, 1, 0));
    vecs.push_back(mk(0, 1, 1, 2'b11, 0, 8'h00, 1, 1, 1));
    vecs.push_back(mk(0, 1, 0, 2'b00, 0, 8'h00, 2, 1, 1));
    vecs.push_back(mk(0, 1, 0, 2'b01, 0, 8'h00, 3, 1, 1));
    vecs.push_back(mk(0, 1, 0, 2'b10, 1, 8'h93, 0, 1, 1));
    // 5: missing sync (reset first so the error flag starts clear)
    vecs.push_back(mk(1, 0, 0, 2'b00, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 2'b01, 0, 8'h00, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 2'b10, 0, 8'h00, 2, 1, 0));
    vecs.push_back(mk(0, 1, 0, 2'b11, 0, 8'h00, 3, 1, 0));
    vecs.push_back(mk(0, 1, 0, 2'b00, 1, 8'h39, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 2'b10, 0, 8'h00, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 2'b01, 0, 8'h00, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 2'b10, 0, 8'h00, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 2'b11, 0, 8'h00, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 2'b00, 0, 8'h00, 0, 0, 1));
    // 6: reset mid-frame while sync_err is set, then a clean frame
    vecs.push_back(mk(0, 1, 1, 2'b01, 0, 8'h00, 1, 1, 1));
    vecs.push_back(mk(0, 1, 0, 2'b10, 0, 8'h00, 2, 1, 1));
    vecs.push_back(mk(1, 0, 0, 2'b00, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 2'b01, 0, 8'h00, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 2'b10, 0, 8'h00, 2, 1, 0));
    vecs.push_back(mk(0, 1, 0, 2'b11, 0, 8'h00, 3, 1, 0));
    vecs.push_back(mk(0, 1, 0, 2'b00, 1, 8'h39, 0, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // out_data holds through idle cycles after a frame
    for (int i = 0; i < 3; i++) apply(mk(0, 0, 0, 2'b00, 0, 8'h00, 0, 1, 0), "idle");
    chk("hold_out_data", 32'(out_data), 32'h39);
    chk("hold_out_valid", 32'(out_valid), 32'h0);

    // Back-to-back random frames: a pulse every 4 cycles
    for (int f = 0; f < 3; f++) begin
      fr = '0;
      for (int k = 0; k < 4; k++) begin
        d = 2'($urandom_range(0, 3));
        fr[k*2 +: 2] = d;
        apply(mk(0, 1, (k == 0), d, (k == 3), fr, 2'(k + 1), 1, 0), $sformatf("b2b%0d_%0d", f, k));
      end
    end

    // Reset mid-frame clears the presented frame as well
    apply(mk(0, 1, 1, 2'b10, 0, 8'h00, 1, 1, 0), "rstmid0");
    apply(mk(0, 1, 0, 2'b01, 0, 8'h00, 2, 1, 0), "rstmid1");
    apply(mk(1, 1, 0, 2'b11, 0, 8'h00, 0, 0, 0), "rstmid2");
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);

    for (int i = 0; i < 5; i++) apply(mk(0, 0, 0, 2'b00, 0, 8'h00, 0, 0, 0), "drain");
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
